// File: rtl/bkm_csd_stim_driver.sv
// Multi-channel two's-complement to canonical-signed-digit converter.
// Each channel recodes serially with Reitwiesner (NAF), or in one cycle by direct mapping.
//
// state  | meaning
// S_IDLE | waiting for an input vector, in_ready follows enable
// S_CONV | recoding, one digit per channel per cycle (or one cycle in direct mode)
// S_HOLD | out_csd complete and held until the consumer accepts
module bkm_csd_stim_driver #(
    parameter int W   = 72,
    parameter int NCH = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [NCH*W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*2*W-1:0]   out_csd,
    output logic                 busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [NCH*W-1:0]     sh_q, sh_d;
    logic [NCH-1:0]       carry_q, carry_d;
    logic [NCH*2*W-1:0]   csd_q, csd_d;
    logic [NCH-1:0][2:0]  naf_res;
    logic                 last_digit;

    // Returns {carry_out, pos, neg}. The last digit absorbs the sign-bit weight: d = c - x.
    function automatic logic [2:0] naf_step(input logic c, input logic xi,
                                            input logic xn, input logic last);
        logic [2:0] r;
        if (last) begin
            r = {1'b0, c & ~xi, ~c & xi};
        end else begin
            r = {(c & xi) | ((c ^ xi) & xn), (c ^ xi) & ~xn, (c ^ xi) & xn};
        end
        return r;
    endfunction

    assign last_digit = (cnt_q == CW'(W - 1));
    assign in_ready   = (state_q == S_IDLE) & enable;
    assign out_valid  = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign out_csd    = csd_q;

    always_comb begin
        naf_res = '0;
        for (int k = 0; k < NCH; k++) begin
            naf_res[k] = naf_step(carry_q[k], sh_q[k*W], sh_q[k*W+1], last_digit);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        csd_d   = csd_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_CONV;
                        sh_d    = in_data;
                        mode_d  = in_mode;
                        carry_d = '0;
                        cnt_d   = '0;
                        csd_d   = '0;
                    end
                end
                S_CONV: begin
                    if (mode_q) begin
                        for (int k = 0; k < NCH; k++) begin
                            for (int i = 0; i < W; i++) begin
                                csd_d[k*2*W + 2*i +: 2] = (i == W - 1) ? {1'b0, sh_q[k*W+i]}
                                                                       : {sh_q[k*W+i], 1'b0};
                            end
                        end
                        state_d = S_HOLD;
                    end else begin
                        // Shift right so the current digit's bit and its neighbour are always at 0 and 1.
                        for (int k = 0; k < NCH; k++) begin
                            carry_d[k] = naf_res[k][2];
                            csd_d[k*2*W + 2*int'(cnt_q) +: 2] = naf_res[k][1:0];
                            sh_d[k*W +: W] = {1'b0, sh_q[k*W+1 +: W-1]};
                        end
                        if (last_digit) begin
                            state_d = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            sh_q    <= '0;
            carry_q <= '0;
            csd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            csd_q   <= csd_d;
        end
    end

endmodule
